// File: rtl/ice40_rgb_wb_seq_if.sv
// Write-only Wishbone link from the RGB sequencer
// to the ice40 LEDDA/RGBA driver slave.
interface ice40_rgb_wb_seq_if;
  logic [4:0]  wb_addr;
  logic [31:0] wb_wdata;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_ack;
  logic [31:0] wb_rdata;

  modport master (
    output wb_addr, wb_wdata, wb_we, wb_cyc,
    input  wb_ack, wb_rdata
  );

  modport slave (
    input  wb_addr, wb_wdata, wb_we, wb_cyc,
    output wb_ack, wb_rdata
  );
endinterface

// File: rtl/ice40_rgb_wb_seq.sv
// Wishbone initiator for the ice40 RGB PWM slave:
// init sequence, then diff-only colour writes.
module ice40_rgb_wb_seq #(
  parameter logic [7:0] CR0      = 8'hC8,
  parameter logic [7:0] BR       = 8'h3F,
  parameter logic [7:0] ONR      = 8'h00,
  parameter logic [7:0] OFR      = 8'h00,
  parameter logic [7:0] BCRR     = 8'h00,
  parameter logic [7:0] BCFR     = 8'h00,
  parameter logic [4:0] CTRL_RUN = 5'h0E,
  parameter int         ACK_TO   = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_r,
  input  logic [7:0] req_g,
  input  logic [7:0] req_b,
  output logic       init_done,
  output logic       err,
  ice40_rgb_wb_seq_if.master bus
);

  typedef enum logic [1:0] {
    S_INIT, S_WR, S_GAP, S_IDLE
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(ACK_TO - 1);

  state_t     state, state_nx;
  logic [3:0] idx;
  logic [7:0] cnt;
  logic [2:0] pend, mask, pick_src;
  logic [1:0] pick;
  logic [7:0] sh  [4];
  logic [7:0] lat [4];
  logic [4:0] t_addr;
  logic [7:0] t_data;
  logic       accept, wr_done, is_req, cyc;
  logic       unused_rdata;

  assign unused_rdata = ^bus.wb_rdata;
  assign accept   = req_valid && req_ready;
  assign mask     = {req_b != sh[2],
                     req_g != sh[1],
                     req_r != sh[0]};
  assign wr_done  = (state == S_WR) &&
                    (bus.wb_ack || cnt == TO_LAST);
  // indices 0..9 are init writes, 12..14 are R/G/B
  assign is_req   = idx[3:2] == 2'b11;
  assign pick_src = (state == S_IDLE) ? mask : pend;

  always_comb begin
    pick = 2'd0;
    priority case (1'b1)
      pick_src[0]: pick = 2'd0;
      pick_src[1]: pick = 2'd1;
      pick_src[2]: pick = 2'd2;
      default:     pick = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_INIT: state_nx = S_WR;
      S_WR:   if (wr_done) state_nx = S_GAP;
      S_GAP: begin
        if (idx < 4'd9)        state_nx = S_WR;
        else if (idx == 4'd9)  state_nx = S_IDLE;
        else if (pend != 3'b0) state_nx = S_WR;
        else                   state_nx = S_IDLE;
      end
      S_IDLE:
        if (accept && mask != 3'b0) state_nx = S_WR;
      default: state_nx = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= 4'd0;
      cnt       <= 8'd0;
      pend      <= 3'b0;
      err       <= 1'b0;
      init_done <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        sh[i]  <= 8'h00;
        lat[i] <= 8'h00;
      end
    end else begin
      unique case (state)
        S_WR: begin
          if (wr_done) begin
            cnt <= 8'd0;
            if (!bus.wb_ack) err <= 1'b1;
            if (idx == 4'd9) init_done <= 1'b1;
            if (is_req) begin
              sh[idx[1:0]]   <= lat[idx[1:0]];
              pend[idx[1:0]] <= 1'b0;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_GAP: begin
          if (idx < 4'd9)        idx <= idx + 4'd1;
          else if (pend != 3'b0) idx <= {2'b11, pick};
        end
        S_IDLE: begin
          if (accept) begin
            lat[0] <= req_r;
            lat[1] <= req_g;
            lat[2] <= req_b;
            pend   <= mask;
            if (mask != 3'b0) idx <= {2'b11, pick};
          end
        end
        default: begin
          idx <= 4'd0;
          cnt <= 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    t_addr = 5'h00;
    t_data = 8'h00;
    unique case (idx)
      4'd0:  begin t_addr = 5'h18; t_data = CR0;  end
      4'd1:  begin t_addr = 5'h19; t_data = BR;   end
      4'd2:  begin t_addr = 5'h1A; t_data = ONR;  end
      4'd3:  begin t_addr = 5'h1B; t_data = OFR;  end
      4'd4:  begin t_addr = 5'h15; t_data = BCRR; end
      4'd5:  begin t_addr = 5'h16; t_data = BCFR; end
      4'd6:  t_addr = 5'h11;
      4'd7:  t_addr = 5'h12;
      4'd8:  t_addr = 5'h13;
      4'd9:  t_data = {3'b000, CTRL_RUN};
      4'd12: begin t_addr = 5'h11; t_data = lat[0]; end
      4'd13: begin t_addr = 5'h12; t_data = lat[1]; end
      4'd14: begin t_addr = 5'h13; t_data = lat[2]; end
      default: ;
    endcase
  end

  always_comb begin
    cyc          = state == S_WR;
    bus.wb_cyc   = cyc;
    bus.wb_we    = cyc;
    bus.wb_addr  = cyc ? t_addr : 5'h00;
    bus.wb_wdata = cyc ? {24'h0, t_data} : 32'h0;
    req_ready    = (state == S_IDLE) && init_done;
  end

endmodule
